// File: rtl/d_phy_pkg.sv
// Shared D-PHY HS lane definitions: sync byte, transmitter states, counter widths.
package d_phy_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'b10111000;

    localparam int ZERO_W  = 8;
    localparam int TRAIL_W = 8;
    localparam int CNT_W   = (ZERO_W > TRAIL_W) ? ZERO_W : TRAIL_W;

    typedef enum logic [2:0] {
        IDLE,
        HS_ZERO,
        SYNC,
        DATA,
        TRAILER
    } tx_state_t;

endpackage

// File: rtl/d_phy_byte_serializer.sv
// Byte-to-pair serializer: shifts one byte out two bits per clock, LSB pair first.
module d_phy_byte_serializer
    import d_phy_pkg::*;
(
    input  logic       clock_p,
    input  logic       reset,
    input  logic       load,
    input  logic       shift_en,
    input  logic [7:0] load_value,
    output logic [1:0] pair,
    output logic       beat_zero
);

    logic [7:0] shift;
    logic [1:0] beat;

    always_ff @(posedge clock_p) begin
        if (reset) begin
            shift <= 8'h00;
            beat  <= 2'd0;
        end else if (load) begin
            shift <= load_value;
            beat  <= 2'd3;
        end else if (shift_en) begin
            shift <= {2'b00, shift[7:2]};
            beat  <= beat - 2'd1;
        end
    end

    assign pair      = shift[1:0];
    assign beat_zero = (beat == 2'd0);

endmodule

// File: rtl/d_phy_transmitter.sv
// HS-only D-PHY data lane transmitter: HS-zero leader, 0xB8 sync, payload, trailer.
module d_phy_transmitter
    import d_phy_pkg::*;
#(
    parameter int ZERO_CYCLES  = 8,
    parameter int TRAIL_CYCLES = 4
) (
    input  logic       clock_p,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       valid,
    input  logic       last,
    output logic       ready,
    output logic [1:0] serial_out,
    output logic       hs_active,
    output logic       underrun
);

    tx_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             last_flag, last_flag_n;
    logic             trail_bit, trail_bit_n;
    logic [1:0]       serial_n;
    logic             hs_n, underrun_n;

    logic             load, shift_en, beat_zero;
    logic [7:0]       load_value;
    logic [1:0]       pair;

    d_phy_byte_serializer u_ser (
        .clock_p    (clock_p),
        .reset      (reset),
        .load       (load),
        .shift_en   (shift_en),
        .load_value (load_value),
        .pair       (pair),
        .beat_zero  (beat_zero)
    );

    always_ff @(posedge clock_p) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            last_flag  <= 1'b0;
            trail_bit  <= 1'b0;
            serial_out <= 2'b00;
            hs_active  <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            last_flag  <= last_flag_n;
            trail_bit  <= trail_bit_n;
            serial_out <= serial_n;
            hs_active  <= hs_n;
            underrun   <= underrun_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        last_flag_n = last_flag;
        trail_bit_n = trail_bit;
        serial_n    = 2'b00;
        hs_n        = 1'b0;
        underrun_n  = 1'b0;
        ready       = 1'b0;
        load        = 1'b0;
        shift_en    = 1'b0;
        load_value  = SYNC_BYTE;

        case (state)
            IDLE: begin
                // The byte stays pending; it is taken at the sync boundary.
                if (valid) begin
                    state_n = HS_ZERO;
                    cnt_n   = CNT_W'(ZERO_CYCLES - 1);
                end
            end

            HS_ZERO: begin
                hs_n = 1'b1;
                if (cnt == '0) begin
                    state_n     = SYNC;
                    load        = 1'b1;
                    load_value  = SYNC_BYTE;
                    last_flag_n = 1'b0;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end

            SYNC, DATA: begin
                hs_n     = 1'b1;
                serial_n = pair;
                shift_en = 1'b1;
                if (beat_zero) begin
                    // pair[1] is bit 7 of the byte finishing now; trailer inverts it.
                    trail_bit_n = pair[1];
                    if (!last_flag) begin
                        ready = 1'b1;
                        if (valid) begin
                            load        = 1'b1;
                            load_value  = data;
                            last_flag_n = last;
                            state_n     = DATA;
                        end else begin
                            underrun_n = 1'b1;
                            state_n    = TRAILER;
                            cnt_n      = CNT_W'(TRAIL_CYCLES - 1);
                        end
                    end else begin
                        state_n = TRAILER;
                        cnt_n   = CNT_W'(TRAIL_CYCLES - 1);
                    end
                end
            end

            TRAILER: begin
                hs_n     = 1'b1;
                serial_n = {~trail_bit, ~trail_bit};
                if (cnt == '0) state_n = IDLE;
                else           cnt_n   = cnt - 1'b1;
            end

            default: state_n = IDLE;
        endcase
    end

endmodule
